// File: rtl/alu_cmd_issuer_pkg.sv
// Shared types for the ALU command issuer: opcode field types, the default
// command record and the issuer FSM state encoding.
package alu_cmd_issuer_pkg;

    localparam int CMD_DATA_W = 5;
    localparam int A_OP_W     = 3;
    localparam int B_OP_W     = 2;

    typedef logic [A_OP_W-1:0] a_op_t;
    typedef logic [B_OP_W-1:0] b_op_t;

    // One queued ALU command at the default operand width.
    typedef struct packed {
        logic signed [CMD_DATA_W-1:0] a;
        logic signed [CMD_DATA_W-1:0] b;
        a_op_t                        a_op;
        b_op_t                        b_op;
        logic                         a_en;
        logic                         b_en;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_RESP  = 2'd3
    } issuer_state_e;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command and result handshake bundle of the ALU command issuer.
// master = command producer / result consumer, slave = the issuer.
interface alu_cmd_issuer_if
    import alu_cmd_issuer_pkg::*;
#(
    parameter int DATA_WIDTH = CMD_DATA_W,
    parameter int TAG_W      = 3,
    parameter int FIFO_DEPTH = 4
) ();

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                         cmd_valid;
    logic                         cmd_ready;
    logic signed [DATA_WIDTH-1:0] cmd_a;
    logic signed [DATA_WIDTH-1:0] cmd_b;
    a_op_t                        cmd_a_op;
    b_op_t                        cmd_b_op;
    logic                         cmd_a_en;
    logic                         cmd_b_en;
    logic                         flush;

    logic                         res_valid;
    logic                         res_ready;
    logic signed [DATA_WIDTH:0]   res_data;
    logic [TAG_W-1:0]             res_tag;
    logic [LVL_W-1:0]             fifo_level;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_a_op, cmd_b_op, cmd_a_en, cmd_b_en,
               flush, res_ready,
        input  cmd_ready, res_valid, res_data, res_tag, fifo_level
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_a_op, cmd_b_op, cmd_a_en, cmd_b_en,
               flush, res_ready,
        output cmd_ready, res_valid, res_data, res_tag, fifo_level
    );

endinterface

// File: rtl/alu_cmd_issuer_fifo.sv
// Synchronous command FIFO. The caller guarantees push_i only when not full
// and pop_i only when not empty; flush_i empties the FIFO on the same edge
// and overrides push/pop. The head entry is presented combinationally.
module alu_cmd_issuer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;

    // Next pointer/count values; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + LW'(push_i) - LW'(pop_i);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: queues commands, issues one per ALU operation with a
// single-cycle alu_en pulse, captures the ALU result one cycle later and
// returns it with a wrapping sequence tag on a valid/ready result port.
module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter int DATA_WIDTH = CMD_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    alu_cmd_issuer_if.slave              bus,
    output logic signed [DATA_WIDTH-1:0] alu_a_o,
    output logic signed [DATA_WIDTH-1:0] alu_b_o,
    output a_op_t                        alu_a_op_o,
    output b_op_t                        alu_b_op_o,
    output logic                         alu_a_en_o,
    output logic                         alu_b_en_o,
    output logic                         alu_en_o,
    output logic                         alu_rst_n_o,
    input  logic signed [DATA_WIDTH:0]   alu_c_i
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] a;
        logic signed [DATA_WIDTH-1:0] b;
        a_op_t                        a_op;
        b_op_t                        b_op;
        logic                         a_en;
        logic                         b_en;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    issuer_state_e              state_q, state_d;
    cmd_t                       push_cmd;
    cmd_t                       head_cmd;
    logic [CMD_W-1:0]           head_raw;
    logic                       fifo_full, fifo_empty;
    logic [LVL_W-1:0]           fifo_level;
    logic                       push, pop, capture;
    logic                       alu_en, res_valid;
    cmd_t                       alu_cmd_q;
    logic signed [DATA_WIDTH:0] res_data_q;
    logic [TAG_W-1:0]           res_tag_q;
    logic [TAG_W-1:0]           next_tag_q;

    // A full FIFO never accepts, even when the head is popped the same cycle.
    assign bus.cmd_ready = !fifo_full && !bus.flush;
    assign push          = bus.cmd_valid && !fifo_full && !bus.flush;

    assign push_cmd.a    = bus.cmd_a;
    assign push_cmd.b    = bus.cmd_b;
    assign push_cmd.a_op = bus.cmd_a_op;
    assign push_cmd.b_op = bus.cmd_b_op;
    assign push_cmd.a_en = bus.cmd_a_en;
    assign push_cmd.b_en = bus.cmd_b_en;
    assign head_cmd      = cmd_t'(head_raw);

    alu_cmd_issuer_fifo #(
        .W     (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.flush),
        .wdata_i (push_cmd),
        .rdata_o (head_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Next-state and per-state strobes of the issue/capture/respond sequence.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        capture   = 1'b0;
        alu_en    = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_en  = 1'b1;
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                capture = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ALU operand/opcode registers, loaded with the head entry as it is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      alu_cmd_q <= '0;
        else if (pop) alu_cmd_q <= head_cmd;
    end

    // Result capture and sequence-tag counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data_q <= '0;
            res_tag_q  <= '0;
            next_tag_q <= '0;
        end else if (capture) begin
            res_data_q <= alu_c_i;
            res_tag_q  <= next_tag_q;
            next_tag_q <= next_tag_q + TAG_W'(1);
        end
    end

    assign alu_a_o        = alu_cmd_q.a;
    assign alu_b_o        = alu_cmd_q.b;
    assign alu_a_op_o     = alu_cmd_q.a_op;
    assign alu_b_op_o     = alu_cmd_q.b_op;
    assign alu_a_en_o     = alu_cmd_q.a_en;
    assign alu_b_en_o     = alu_cmd_q.b_en;
    assign alu_en_o       = alu_en;
    assign alu_rst_n_o    = ~rst;

    assign bus.res_valid  = res_valid;
    assign bus.res_data   = res_data_q;
    assign bus.res_tag    = res_tag_q;
    assign bus.fifo_level = fifo_level;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer with a stand-in registered ALU. The ALU stub holds C
// for null ops and otherwise produces (A+B) xor {a_op,b_op}; the reference model
// replays the stream of issued commands through the same rule.
module tb_alu_cmd_issuer;
    import alu_cmd_issuer_pkg::*;

    logic clk;
    logic rst;
    logic signed [4:0] alu_a, alu_b;
    a_op_t             alu_a_op;
    b_op_t             alu_b_op;
    logic              alu_a_en, alu_b_en, alu_en, alu_rst_n;
    logic signed [5:0] alu_c;
    alu_cmd_t          alu_in;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int en_cnt = 0;

    alu_cmd_t          acc_q[$];
    logic signed [5:0] obs_d[$];
    logic [2:0]        obs_t[$];
    int                obs_c[$];

    logic signed [5:0] m_c;
    logic [2:0]        m_tag;

    alu_cmd_issuer_if #(.DATA_WIDTH(5), .TAG_W(3), .FIFO_DEPTH(4)) bus ();

    alu_cmd_issuer #(.DATA_WIDTH(5), .FIFO_DEPTH(4), .TAG_W(3)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_a_op_o(alu_a_op), .alu_b_op_o(alu_b_op),
        .alu_a_en_o(alu_a_en), .alu_b_en_o(alu_b_en), .alu_en_o(alu_en),
        .alu_rst_n_o(alu_rst_n), .alu_c_i(alu_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [5:0] alu_fn(input alu_cmd_t c, input logic signed [5:0] held);
        logic signed [5:0] s;
        if (!c.a_en && !c.b_en) return held;
        s = {c.a[4], c.a} + {c.b[4], c.b};
        return s ^ {1'b0, c.a_op, c.b_op};
    endfunction

    always_comb begin
        alu_in      = '0;
        alu_in.a    = alu_a;
        alu_in.b    = alu_b;
        alu_in.a_op = alu_a_op;
        alu_in.b_op = alu_b_op;
        alu_in.a_en = alu_a_en;
        alu_in.b_en = alu_b_en;
    end

    always @(posedge clk or negedge alu_rst_n) begin
        if (!alu_rst_n)  alu_c <= '0;
        else if (alu_en) alu_c <= alu_fn(alu_in, alu_c);
    end

    always @(negedge clk) begin : mon
        alu_cmd_t mc;
        cyc++;
        if (!rst) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                mc.a = bus.cmd_a; mc.b = bus.cmd_b; mc.a_op = bus.cmd_a_op;
                mc.b_op = bus.cmd_b_op; mc.a_en = bus.cmd_a_en; mc.b_en = bus.cmd_b_en;
                acc_q.push_back(mc);
            end
            if (bus.res_valid && bus.res_ready) begin
                obs_d.push_back(bus.res_data);
                obs_t.push_back(bus.res_tag);
                obs_c.push_back(cyc);
            end
            if (alu_en) en_cnt++;
        end
    end

    task automatic model_reset();
        m_c = '0;
        m_tag = '0;
    endtask

    task automatic model_next(input alu_cmd_t c, output logic signed [5:0] ed, output logic [2:0] et);
        ed = alu_fn(c, m_c);
        m_c = ed;
        et = m_tag;
        m_tag = m_tag + 3'd1;
    endtask

    task automatic clear_obs();
        acc_q.delete(); obs_d.delete(); obs_t.delete(); obs_c.delete();
    endtask

    function automatic alu_cmd_t rand_cmd();
        alu_cmd_t c;
        c.a = 5'($urandom); c.b = 5'($urandom);
        c.a_op = 3'($urandom); c.b_op = 2'($urandom);
        c.a_en = 1'($urandom); c.b_en = 1'($urandom);
        return c;
    endfunction

    task automatic drive_cmd(input alu_cmd_t c);
        bus.cmd_a = c.a; bus.cmd_b = c.b; bus.cmd_a_op = c.a_op; bus.cmd_b_op = c.b_op;
        bus.cmd_a_en = c.a_en; bus.cmd_b_en = c.b_en; bus.cmd_valid = 1'b1;
    endtask

    task automatic push_cmd(input alu_cmd_t c);
        int n = 0;
        bit done = 0;
        drive_cmd(c);
        while (!done) begin
            @(negedge clk);
            if (bus.cmd_ready) done = 1;
            @(posedge clk); #1;
            n++;
            if (!done && n > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL push_timeout got=no_accept want=accept");
                done = 1;
            end
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int k = 0;
        while (obs_d.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        ok = (obs_d.size() >= n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        clear_obs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_res_valid got=%0b want=0", bus.res_valid); end
        n_cmp++; if (bus.res_data !== 6'sd0) begin n_bad++; $display("FAIL rst_res_data got=%0d want=0", bus.res_data); end
        n_cmp++; if (bus.res_tag !== 3'd0) begin n_bad++; $display("FAIL rst_res_tag got=%0d want=0", bus.res_tag); end
        n_cmp++; if (alu_en !== 1'b0) begin n_bad++; $display("FAIL rst_alu_en got=%0b want=0", alu_en); end
        n_cmp++; if (bus.fifo_level !== 3'd0) begin n_bad++; $display("FAIL rst_level got=%0d want=0", bus.fifo_level); end
        n_cmp++; if ({alu_a, alu_b, alu_a_op, alu_b_op, alu_a_en, alu_b_en} !== 17'd0) begin
            n_bad++; $display("FAIL rst_alu_regs got=%0h want=0", {alu_a, alu_b, alu_a_op, alu_b_op, alu_a_en, alu_b_en}); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready got=%0b want=1", bus.cmd_ready); end
        n_cmp++; if (alu_rst_n !== 1'b0) begin n_bad++; $display("FAIL rst_alu_rst_n got=%0b want=0", alu_rst_n); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        clear_obs();
        @(negedge clk);
        n_cmp++; if (alu_rst_n !== 1'b1) begin n_bad++; $display("FAIL run_alu_rst_n got=%0b want=1", alu_rst_n); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        alu_cmd_t c;
        logic signed [5:0] ed;
        logic [2:0] et;
        int en0;
        clear_obs();
        bus.res_ready = 1'b1;
        en0 = en_cnt;
        c = '0; c.a = 5'sd7; c.b = 5'sd3; c.a_en = 1'b1;
        drive_cmd(c);
        @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got=%0b want=1", bus.cmd_ready); end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (alu_en !== 1'b0) begin n_bad++; $display("FAIL single_en_early got=%0b want=0", alu_en); end
        n_cmp++; if (bus.fifo_level !== 3'd1) begin n_bad++; $display("FAIL single_level1 got=%0d want=1", bus.fifo_level); end
        @(negedge clk);
        n_cmp++; if (alu_en !== 1'b1) begin n_bad++; $display("FAIL single_en got=%0b want=1", alu_en); end
        n_cmp++; if (alu_a !== 5'sd7 || alu_b !== 5'sd3 || alu_a_en !== 1'b1 || alu_b_en !== 1'b0) begin
            n_bad++; $display("FAIL single_operands got=%0d,%0d,%0b,%0b want=7,3,1,0", alu_a, alu_b, alu_a_en, alu_b_en); end
        n_cmp++; if (bus.fifo_level !== 3'd0) begin n_bad++; $display("FAIL single_level0 got=%0d want=0", bus.fifo_level); end
        @(negedge clk);
        n_cmp++; if (alu_en !== 1'b0 || bus.res_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_capt got=en%0b,v%0b want=en0,v0", alu_en, bus.res_valid); end
        model_next(c, ed, et);
        @(negedge clk);
        n_cmp++; if (bus.res_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%0b want=1", bus.res_valid); end
        n_cmp++; if (bus.res_data !== 6'sd10) begin n_bad++; $display("FAIL single_data got=%0d want=10", bus.res_data); end
        n_cmp++; if (bus.res_tag !== et) begin n_bad++; $display("FAIL single_tag got=%0d want=%0d", bus.res_tag, et); end
        @(negedge clk);
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL single_consumed got=%0b want=0", bus.res_valid); end
        n_cmp++; if (en_cnt - en0 !== 1) begin n_bad++; $display("FAIL single_en_count got=%0d want=1", en_cnt - en0); end
        n_cmp++; if (ed !== 6'sd10 || obs_d.size() !== 1) begin n_bad++; $display("FAIL single_results got=%0d want=1", obs_d.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_ops();
        alu_cmd_t cl[8];
        logic signed [5:0] ed;
        logic [2:0] et;
        bit ok;
        clear_obs();
        bus.res_ready = 1'b1;
        for (int i = 0; i < 8; i++) cl[i] = rand_cmd();
        cl[0].b = -5'sd16; cl[0].b_op = 2'd3; cl[0].a_en = 1'b1; cl[0].b_en = 1'b1;
        cl[1] = '0; cl[1].b_en = 1'b1;
        cl[5].a_en = 1'b0; cl[5].b_en = 1'b0;
        for (int i = 0; i < 8; i++) push_cmd(cl[i]);
        wait_obs(8, 100, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL ops_timeout got=%0d want=8", obs_d.size()); end
        for (int i = 0; i < 8; i++) begin
            model_next(cl[i], ed, et);
            if (i < obs_d.size()) begin
                n_cmp++; if (obs_d[i] !== ed || obs_t[i] !== et) begin
                    n_bad++; $display("FAIL ops_result[%0d] got=%0d/t%0d want=%0d/t%0d", i, obs_d[i], obs_t[i], ed, et); end
                if (i > 0) begin
                    n_cmp++; if (obs_c[i] - obs_c[i-1] !== 3) begin
                        n_bad++; $display("FAIL ops_spacing[%0d] got=%0d want=3", i, obs_c[i] - obs_c[i-1]); end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        alu_cmd_t cl[6];
        logic signed [5:0] ed[5];
        logic [2:0] et[5];
        bit ok;
        clear_obs();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 6; i++) cl[i] = rand_cmd();
        cl[0].a_en = 1'b1;
        for (int i = 0; i < 5; i++) model_next(cl[i], ed[i], et[i]);
        for (int i = 0; i < 5; i++) push_cmd(cl[i]);
        repeat (2) begin @(posedge clk); #1; end
        drive_cmd(cl[5]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d] got=%0b want=0", k, bus.cmd_ready); end
            n_cmp++; if (bus.fifo_level !== 3'd4) begin n_bad++; $display("FAIL bp_level[%0d] got=%0d want=4", k, bus.fifo_level); end
            n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== ed[0] || bus.res_tag !== et[0]) begin
                n_bad++; $display("FAIL bp_hold[%0d] got=v%0b,%0d,t%0d want=v1,%0d,t%0d", k, bus.res_valid, bus.res_data, bus.res_tag, ed[0], et[0]); end
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        n_cmp++; if (acc_q.size() !== 5) begin n_bad++; $display("FAIL bp_accepted got=%0d want=5", acc_q.size()); end
        bus.res_ready = 1'b1;
        wait_obs(5, 100, ok);
        repeat (6) begin @(posedge clk); #1; end
        n_cmp++; if (obs_d.size() !== 5) begin n_bad++; $display("FAIL bp_count got=%0d want=5", obs_d.size()); end
        for (int i = 0; i < 5 && i < obs_d.size(); i++) begin
            n_cmp++; if (obs_d[i] !== ed[i] || obs_t[i] !== et[i]) begin
                n_bad++; $display("FAIL bp_result[%0d] got=%0d/t%0d want=%0d/t%0d", i, obs_d[i], obs_t[i], ed[i], et[i]); end
        end
        n_cmp++; if (bus.fifo_level !== 3'd0) begin n_bad++; $display("FAIL bp_end_level got=%0d want=0", bus.fifo_level); end
    endtask

    task automatic test_flush();
        alu_cmd_t c1, c2, c3;
        logic signed [5:0] ed;
        logic [2:0] et;
        bit ok;
        int en0;
        clear_obs();
        bus.res_ready = 1'b1;
        en0 = en_cnt;
        c1 = rand_cmd(); c1.a_en = 1'b1;
        c2 = rand_cmd(); c3 = rand_cmd();
        drive_cmd(c1);
        @(posedge clk); #1;
        drive_cmd(c2);
        @(posedge clk); #1;
        drive_cmd(c3);
        bus.flush = 1'b1;
        @(negedge clk);
        n_cmp++; if (alu_en !== 1'b1) begin n_bad++; $display("FAIL flush_in_issue got=%0b want=1", alu_en); end
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got=%0b want=0", bus.cmd_ready); end
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.fifo_level !== 3'd0) begin n_bad++; $display("FAIL flush_level got=%0d want=0", bus.fifo_level); end
        wait_obs(1, 20, ok);
        repeat (10) begin @(posedge clk); #1; end
        model_next(c1, ed, et);
        n_cmp++; if (obs_d.size() !== 1) begin n_bad++; $display("FAIL flush_count got=%0d want=1", obs_d.size()); end
        n_cmp++; if (acc_q.size() !== 2) begin n_bad++; $display("FAIL flush_accepted got=%0d want=2", acc_q.size()); end
        if (obs_d.size() > 0) begin
            n_cmp++; if (obs_d[0] !== ed || obs_t[0] !== et) begin
                n_bad++; $display("FAIL flush_result got=%0d/t%0d want=%0d/t%0d", obs_d[0], obs_t[0], ed, et); end
        end
        n_cmp++; if (en_cnt - en0 !== 1) begin n_bad++; $display("FAIL flush_en_count got=%0d want=1", en_cnt - en0); end
    endtask

    task automatic test_reset_mid();
        alu_cmd_t c1, c2, c3;
        logic signed [5:0] ed;
        logic [2:0] et;
        bit ok;
        clear_obs();
        bus.res_ready = 1'b1;
        c1 = rand_cmd(); c2 = rand_cmd(); c3 = rand_cmd(); c3.b_en = 1'b1;
        push_cmd(c1);
        push_cmd(c2);
        @(negedge clk);
        n_cmp++; if (alu_en !== 1'b1) begin n_bad++; $display("FAIL rmid_issue got=%0b want=1", alu_en); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got=%0b want=0", bus.res_valid); end
        n_cmp++; if (bus.fifo_level !== 3'd0) begin n_bad++; $display("FAIL rmid_level got=%0d want=0", bus.fifo_level); end
        n_cmp++; if (alu_en !== 1'b0) begin n_bad++; $display("FAIL rmid_alu_en got=%0b want=0", alu_en); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        clear_obs();
        push_cmd(c3);
        wait_obs(1, 20, ok);
        repeat (8) begin @(posedge clk); #1; end
        model_next(c3, ed, et);
        n_cmp++; if (obs_d.size() !== 1) begin n_bad++; $display("FAIL rmid_count got=%0d want=1", obs_d.size()); end
        if (obs_d.size() > 0) begin
            n_cmp++; if (obs_t[0] !== 3'd0 || obs_d[0] !== ed) begin
                n_bad++; $display("FAIL rmid_result got=%0d/t%0d want=%0d/t0", obs_d[0], obs_t[0], ed); end
        end
    endtask

    task automatic test_tag_wrap();
        alu_cmd_t cl[9];
        logic signed [5:0] ed;
        logic [2:0] et;
        bit ok;
        int en0;
        do_reset();
        bus.res_ready = 1'b1;
        en0 = en_cnt;
        for (int i = 0; i < 9; i++) cl[i] = rand_cmd();
        for (int i = 0; i < 9; i++) push_cmd(cl[i]);
        wait_obs(9, 200, ok);
        repeat (5) begin @(posedge clk); #1; end
        n_cmp++; if (obs_d.size() !== 9) begin n_bad++; $display("FAIL wrap_count got=%0d want=9", obs_d.size()); end
        n_cmp++; if (en_cnt - en0 !== 9) begin n_bad++; $display("FAIL wrap_en_count got=%0d want=9", en_cnt - en0); end
        for (int i = 0; i < 9 && i < obs_d.size(); i++) begin
            model_next(cl[i], ed, et);
            n_cmp++; if (obs_t[i] !== 3'(i) || obs_d[i] !== ed) begin
                n_bad++; $display("FAIL wrap_result[%0d] got=%0d/t%0d want=%0d/t%0d", i, obs_d[i], obs_t[i], ed, 3'(i)); end
        end
    endtask

    task automatic test_random();
        alu_cmd_t cl[20];
        logic signed [5:0] ed;
        logic [2:0] et;
        bit ok;
        bit push_done;
        clear_obs();
        push_done = 0;
        for (int i = 0; i < 20; i++) cl[i] = rand_cmd();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    push_cmd(cl[i]);
                end
                push_done = 1;
            end
            begin
                int k = 0;
                while (!push_done && k < 2000) begin
                    @(posedge clk); #1;
                    bus.res_ready = 1'($urandom);
                    k++;
                end
                bus.res_ready = 1'b1;
            end
        join
        wait_obs(20, 200, ok);
        n_cmp++; if (obs_d.size() !== 20) begin n_bad++; $display("FAIL rand_count got=%0d want=20", obs_d.size()); end
        for (int i = 0; i < 20 && i < obs_d.size(); i++) begin
            model_next(cl[i], ed, et);
            n_cmp++; if (obs_d[i] !== ed || obs_t[i] !== et) begin
                n_bad++; $display("FAIL rand_result[%0d] got=%0d/t%0d want=%0d/t%0d", i, obs_d[i], obs_t[i], ed, et); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_a_op = '0; bus.cmd_b_op = '0;
        bus.cmd_a_en = 1'b0; bus.cmd_b_en = 1'b0; bus.flush = 1'b0; bus.res_ready = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_ops();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_tag_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
